// File: rtl/store_monitor.sv
// store_monitor: checks committed stores, in order, against a programmable table of expected {address, data} pairs.
// Define STORE_MON_WATCHDOG_EN to add a RUN-state cycle budget of TIMEOUT_CYCLES (fail code 11).
module store_monitor #(
  parameter int DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [31:0]   cfg_adr,
  input  logic [31:0]   cfg_data,
  input  logic [CW-1:0] cfg_count,
  input  logic          start,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_code,
  output logic [CW-1:0] store_cnt,
  output logic [31:0]   bad_adr,
  output logic [31:0]   bad_data
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n, store_cnt_n;
  logic [1:0] fail_code_n;
  logic [31:0] bad_adr_n, bad_data_n;
  logic [63:0] tbl [DEPTH];
  logic restart, hit, last, timeout;
  assign restart = start && state != RUN;
  assign hit = tbl[idx] == {dataadr, writedata};
  assign last = {1'b0, idx} == cnt - CW'(1);
  assign busy = state == RUN;
  assign done = state == PASS || state == FAIL;
  assign pass = state == PASS;
`ifdef STORE_MON_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  always_ff @(posedge clk)
    if (reset || restart) wd <= '0;
    else if (state == RUN) wd <= wd + WW'(1);
  assign timeout = state == RUN && wd == WW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign timeout = 1'b0;
`endif
  // Table is deliberately not reset; a write issued with start lands before any store is compared.
  always_ff @(posedge clk)
    if (cfg_we && state != RUN) tbl[cfg_idx] <= {cfg_adr, cfg_data};
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    store_cnt_n = store_cnt;
    fail_code_n = fail_code;
    bad_adr_n = bad_adr;
    bad_data_n = bad_data;
    if (restart) begin
      state_n = cfg_count == '0 ? PASS : RUN;
      cnt_n = cfg_count;
      idx_n = '0;
      store_cnt_n = '0;
      fail_code_n = 2'b00;
      bad_adr_n = '0;
      bad_data_n = '0;
    end else if (state == RUN && memwrite) begin
      state_n = !hit ? FAIL : last ? PASS : RUN;
      idx_n = hit && !last ? idx + IW'(1) : idx;
      store_cnt_n = !hit ? store_cnt : last ? cnt : store_cnt + CW'(1);
      fail_code_n = hit ? 2'b00 : 2'b01;
      bad_adr_n = hit ? 32'd0 : dataadr;
      bad_data_n = hit ? 32'd0 : writedata;
    end else if (state == PASS && memwrite) begin
      state_n = FAIL;
      fail_code_n = 2'b10;
      bad_adr_n = dataadr;
      bad_data_n = writedata;
    end else if (timeout) begin
      state_n = FAIL;
      fail_code_n = 2'b11;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      store_cnt <= '0;
      fail_code <= 2'b00;
      bad_adr <= '0;
      bad_data <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      store_cnt <= store_cnt_n;
      fail_code <= fail_code_n;
      bad_adr <= bad_adr_n;
      bad_data <= bad_data_n;
    end
endmodule

// File: doc/store_monitor.md
# store_monitor

Synthesizable store-bus checker sitting directly downstream of the single-cycle MIPS `top`, consuming its `memwrite`/`dataadr`/`writedata` outputs. It holds a programmable table of expected stores and compares each committed store, in order, against it. It reports pass, or the first failure with its cause and the offending store. It replaces ad-hoc negedge checks in program benches and can also be mapped to hardware for on-board self-test.

## Interface
- `DEPTH`, 8: number of expected-store table entries (power of two, ≥2).
- `TIMEOUT_CYCLES`, 1024: RUN-state cycle budget (used only with watchdog compiled in).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state and outputs.
- `cfg_we` in 1: write table entry `cfg_idx`; accepted only in IDLE, PASS or FAIL.
- `cfg_idx` in $clog2(DEPTH): table index.
- `cfg_adr` in 32: expected store address.
- `cfg_data` in 32: expected store data.
- `cfg_count` in $clog2(DEPTH)+1: number of expected stores (0..DEPTH), sampled on `start`.
- `start` in 1: one-cycle pulse that begins a check.
- `memwrite`, `dataadr`, `writedata` in 1/32/32: processor store bus; a store commits on a rising edge with `memwrite`=1.
- `busy` out 1: state is RUN.
- `done` out 1: state is PASS or FAIL.
- `pass` out 1: state is PASS.
- `fail_code` out 2: 00 none, 01 mismatch, 10 extra store, 11 timeout.
- `store_cnt` out $clog2(DEPTH)+1: matched stores so far.
- `bad_adr`, `bad_data` out 32/32: offending store for codes 01 and 10, otherwise 0.

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset enters IDLE; all outputs 0. The table is not cleared by reset, so its contents after reset are undefined until written.
- IDLE:
  - `start` with `cfg_count`=0 goes to PASS.
  - `start` with `cfg_count`>0 goes to RUN, latches the count, and clears `idx`, `store_cnt` and the watchdog.
  - Stores are ignored.
- RUN, on a committed store, compares `{dataadr,writedata}` to entry[`idx`]:
  - Match with `idx`=count−1: go to PASS, `store_cnt`=count.
  - Match otherwise: `idx`++, `store_cnt`++.
  - Mismatch: go to FAIL with code 01 and capture the store into `bad_adr`/`bad_data`.
- RUN ignores `cfg_we` and `start`.
- PASS: a further committed store goes to FAIL with code 10 and capture; `store_cnt` is unchanged.
- FAIL is sticky; stores are ignored.
- PASS/FAIL with `start` restarts exactly as from IDLE, clearing `fail_code`, `bad_*` and `store_cnt`.
- `cfg_we` together with `start` in the same cycle: the table write lands first, so the check uses the new entry.
- Comparison is full 32-bit equality on both fields; there is no byte masking.

## Timing
- All outputs are registered. A store committing on edge N updates `store_cnt`/`pass`/`fail_code` at edge N, so they are visible in the cycle after N. Negedge samplers see them half a cycle after the commit.
- `start` on edge N makes `busy`=1 from edge N.
- Back-to-back stores on consecutive edges are each checked; no store is dropped.
- `reset` has priority over every event, including `start` and a store on the same edge.
- Watchdog, when compiled in, and a store on the same edge: the store is evaluated and the timeout is suppressed for that edge.

## Configuration
- `STORE_MON_WATCHDOG_EN` defined:
  - A cycle counter runs in RUN, cleared on `start`.
  - Counter reaching `TIMEOUT_CYCLES` without completion goes to FAIL with code 11; `bad_*` stays 0.
- `STORE_MON_WATCHDOG_EN` not defined:
  - No counter logic is present and code 11 is never produced.
  - RUN waits indefinitely.

## Test plan
- Single store: table[0]={84,7}, count=1, start, then store (84,7) -> next cycle `pass`=1, `done`=1, `store_cnt`=1, `fail_code`=00.
- Mismatch: table {80,5},{84,7}, then stores (80,5),(84,9) -> after second store FAIL, code 01, `bad_adr`=84, `bad_data`=9, `store_cnt`=1.
- Extra store: count=1 passes on (84,7), then store (88,1) -> FAIL, code 10, `bad_adr`=88, `pass`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): start with count=1 and no stores -> FAIL code 11 exactly 16 cycles after start. With the macro off, still `busy`=1 after 100 cycles.
- Reset mid-run: after 1 of 3 stores matched, assert `reset` one cycle -> all outputs 0, state IDLE. A store during reset is ignored. Restart with an unchanged table, replay all 3 stores -> PASS.
- Edge cases:
  - Start with count=0 -> PASS in one cycle.
  - `cfg_we` on index 0 with `start` in the same cycle -> the check uses the new entry.
  - Stores on consecutive edges matching entries 0..7 with DEPTH=8 -> PASS, `store_cnt`=8.
